dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Round-robin arbiter that shares one single-port 256x64 data memory among up to four requesters, for example a node's CPU load/store port and its NIC staging logic. It sits between the requesters and the dmem strobes (`memEn`, `memWrEn`, `memAddr`, `dataIn`, `dataOut`). It issues at most one memory access per cycle and routes each read result back to the requester that issued it. An optional lock mode holds the port for atomic read-modify-write sequences.

## Interface
- `NUM_REQ`, 4, number of requesters (2..4)
- `ADDR_W`, 8, memory word-address width
- `DATA_W`, 64, data width
- `clk` in 1: system clock; all state updates on its rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `req` in NUM_REQ: per-requester access request, level, held until granted
- `req_wr` in NUM_REQ: 1 = write, 0 = read; qualified by `req`
- `req_lock` in NUM_REQ: lock request (used only with the macro)
- `req_addr` in NUM_REQ*ADDR_W: packed addresses; requester 0 in the most-significant slice
- `req_wdata` in NUM_REQ*DATA_W: packed write data, same packing as `req_addr`
- `gnt` out NUM_REQ: one-hot grant, same cycle as the accepted request
- `rvalid` out NUM_REQ: one-hot read-return strobe
- `rdata` out DATA_W: read data, valid when any `rvalid` bit is set
- `memEn` out 1: memory enable
- `memWrEn` out 1: memory write enable
- `memAddr` out ADDR_W: memory address
- `dataIn` out DATA_W: write data to memory
- `dataOut` in DATA_W: read data from memory; registered in memory, valid one cycle after `memEn`

## Operation
- Priority pointer `ptr` (log2 NUM_REQ bits), reset 0. Search order is `ptr`, `ptr+1`, … modulo NUM_REQ; the first set `req` bit wins.
- `gnt` is combinational from registered `ptr`, the lock state and `req`. It is never asserted while `reset` is high.
- On any grant to requester i, `ptr` <= (i+1) mod NUM_REQ, unless the access is locked (see Configuration).
- Memory strobes are driven combinationally from the granted requester: `memEn`=1, `memWrEn`=`req_wr[i]`, `memAddr`/`dataIn` taken from slice i.
- With no grant: `memEn`=0, `memWrEn`=0, `memAddr`=0, `dataIn`=0.
- Read return tracking: registered `rd_pend` (1 bit) and `rd_tag` (index), reset 0/0.
  - A granted read sets `rd_pend`=1 and `rd_tag`=i for the next cycle.
  - In that next cycle, `rvalid[rd_tag]`=1 and `rdata`=`dataOut`. `rdata` is 0 whenever no `rvalid` bit is set.
- Writes produce no return strobe.
- Back-to-back reads from different requesters are fully pipelined: one grant and one return per cycle.
- A requester may issue its next request in the same cycle as its `rvalid`.
- Starvation bound without lock: a held `req` is granted within NUM_REQ grant cycles.
- Reset asserted mid-operation:
  - `gnt`, `rvalid` and `memEn` drop to 0 immediately.
  - `rd_pend` is cleared, so an in-flight read is discarded.
  - `ptr`=0 and any lock is released.

## Timing
- Grant latency 0 cycles: `req` high in cycle T (with priority) gives `gnt` high in cycle T.
- Memory samples at the rising edge ending cycle T.
- Read data latency 1 cycle: `rvalid`/`rdata` in cycle T+1.
- Write is committed at the rising edge ending cycle T.
- Requesters must hold `req_wr`, `req_addr`, `req_wdata` stable while `req` is high and `gnt` is low.
- The requester deasserts `req` (or presents a new request) in the cycle after `gnt`.
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `memEn`=0, `memWrEn`=0, `memAddr`=0, `dataIn`=0.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - Two-state FSM, IDLE and LOCKED, with registered owner index; reset state IDLE.
  - IDLE -> LOCKED when requester i is granted with `req_lock[i]`=1. Owner = i; `ptr` does not advance.
  - In LOCKED, only the owner can be granted; other requests wait.
  - LOCKED -> IDLE on a grant to the owner with `req_lock`=0; `ptr` then advances to owner+1.
  - LOCKED -> IDLE also when the owner drops both `req` and `req_lock` in the same cycle; `ptr` <= owner+1.
  - Reset in LOCKED returns the FSM to IDLE.
- `DMEM_ARB_LOCK_EN` not defined: `req_lock` is ignored, no FSM state exists, and behaviour is plain round-robin.

## Structure
- Shared package or include holds `DMEM_ADDR_W`=8, `DMEM_DATA_W`=64, `DMEM_NUM_REQ`=4 and the lock FSM state encodings (IDLE=0, LOCKED=1).
- One sub-module, `arb_rr_pick`: a combinational rotating-priority one-hot picker (inputs `req`, `ptr`, `mask`; outputs one-hot grant and winner index).
- The lock logic, the pointer register and the read-return tracking stay in the top module.

## Test plan
- Single read: dmem[0x10]=0xDEADBEEF00000001; requester 2 reads 0x10 → `gnt`=0010 in T, `memEn`=1, `memAddr`=0x10; `rvalid`=0010 and `rdata`=0xDEADBEEF00000001 in T+1.
- Fairness: all four `req` held high for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3.
- Write then read: requester 1 writes 0x0123456789ABCDEF to 0x05; requester 0 reads 0x05 the next cycle → `rvalid`=1000, `rdata`=0x0123456789ABCDEF.
- Pipelined reads: requesters 0 and 3 each issue 4 reads of 0x00..0x03 → one return per cycle, tags alternating 0,3, data matching memory.
- Reset mid-read: assert `reset` in the cycle after a read grant → `rvalid`=0 immediately; after release the first grant goes to requester 0.
- Lock (`DMEM_ARB_LOCK_EN`): requester 1 issues a locked read of 0x20 while requester 0 is requesting → requester 1 then writes 0x20 unlocked with no intervening grant to 0; requester 0 is granted in the following cycle.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared widths, lock FSM encodings and round-robin helper for dmem_port_arbiter.
package dmem_port_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_W  = 8;
    localparam int unsigned DMEM_DATA_W  = 64;
    localparam int unsigned DMEM_NUM_REQ = 4;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // Index of the requester after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority picker: first masked request at or after ptr wins.
module arb_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     cand;
    int unsigned      pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        cand    = req & mask;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (!any && cand[pos_idx]) begin
                any          = 1'b1;
                gnt[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_REQ requesters.
// Optional atomic lock mode is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DMEM_NUM_REQ,
    parameter int unsigned ADDR_W  = DMEM_ADDR_W,
    parameter int unsigned DATA_W  = DMEM_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      memEn,
    output logic                      memWrEn,
    output logic [ADDR_W-1:0]         memAddr,
    output logic [DATA_W-1:0]         dataIn,
    input  logic [DATA_W-1:0]         dataOut
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] wr_v;
    logic [NUM_REQ-1:0] mask_c;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt_v;
    logic [NUM_REQ-1:0] rv_v;
    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_load_val;
    logic [IDX_W-1:0]   rd_tag;
    logic               pick_any;
    logic               gnt_any;
    logic               ptr_load;
    logic               rd_pend;

    // Port vectors carry requester 0 in the MSB; internally bit i is requester i.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
        assign req_v[g]                = req[NUM_REQ-1-g];
        assign wr_v[g]                 = req_wr[NUM_REQ-1-g];
        assign addr_a[g]               = req_addr[(NUM_REQ-1-g)*ADDR_W +: ADDR_W];
        assign wdata_a[g]              = req_wdata[(NUM_REQ-1-g)*DATA_W +: DATA_W];
        assign gnt[NUM_REQ-1-g]        = gnt_v[g];
        assign rvalid[NUM_REQ-1-g]     = rv_v[g];
    end

    arb_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req_v),
        .ptr  (ptr),
        .mask (mask_c),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Reset blanks the grant path at once; flops see the ungated pick.
    assign gnt_any = pick_any & ~reset;
    assign gnt_v   = reset ? '0 : pick_gnt;

    always_comb begin
        memEn   = gnt_any;
        memWrEn = 1'b0;
        memAddr = '0;
        dataIn  = '0;
        if (gnt_any) begin
            memWrEn = wr_v[pick_idx];
            memAddr = addr_a[pick_idx];
            dataIn  = wdata_a[pick_idx];
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0] lock_v;
    lock_state_e        state;
    lock_state_e        state_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_nxt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lock
        assign lock_v[g] = req_lock[NUM_REQ-1-g];
    end

    // While locked only the owner may be picked.
    assign mask_c = (state == LOCK_LOCKED) ? (NUM_REQ'(1) << owner) : '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOCK_IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            LOCK_IDLE: begin
                if (pick_any && lock_v[pick_idx]) begin
                    state_nxt = LOCK_LOCKED;
                    owner_nxt = pick_idx;
                end
            end
            LOCK_LOCKED: begin
                if (pick_any && !lock_v[owner]) begin
                    state_nxt = LOCK_IDLE;
                end else if (!req_v[owner] && !lock_v[owner]) begin
                    state_nxt = LOCK_IDLE;
                end
            end
            default: state_nxt = LOCK_IDLE;
        endcase
    end

    // Pointer holds across a locked sequence and resumes after the owner.
    always_comb begin
        ptr_load     = 1'b0;
        ptr_load_val = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
        case (state)
            LOCK_IDLE: begin
                ptr_load = pick_any && !lock_v[pick_idx];
            end
            LOCK_LOCKED: begin
                ptr_load     = (state_nxt == LOCK_IDLE);
                ptr_load_val = IDX_W'(rr_next(32'(owner), NUM_REQ));
            end
            default: ptr_load = 1'b0;
        endcase
    end
`else
    logic unused_lock;

    assign unused_lock  = ^req_lock;
    assign mask_c       = '1;
    assign ptr_load     = pick_any;
    assign ptr_load_val = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (ptr_load) begin
            ptr <= ptr_load_val;
        end
    end

    // Read-return tracking: memory answers one cycle after a granted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_tag  <= '0;
        end else begin
            rd_pend <= pick_any && !wr_v[pick_idx];
            if (pick_any && !wr_v[pick_idx]) begin
                rd_tag <= pick_idx;
            end
        end
    end

    always_comb begin
        rv_v  = '0;
        rdata = '0;
        if (rd_pend) begin
            rv_v[rd_tag] = 1'b1;
            rdata        = dataOut;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed vectors, expected port and return queues.
module tb_dmem_port_arbiter;

    typedef struct packed {
        logic [3:0]  g;
        logic        en;
        logic        wr;
        logic [7:0]  a;
        logic [63:0] d;
    } port_exp_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] data;
        int          due;
    } rd_exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   req_wr;
    logic [3:0]   req_lock;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   gnt;
    logic [3:0]   rvalid;
    logic [63:0]  rdata;
    logic         memEn;
    logic         memWrEn;
    logic [7:0]   memAddr;
    logic [63:0]  dataIn;
    logic [63:0]  dataOut;

    logic [63:0]  mem [256];
    port_exp_t    exp_q [$];
    rd_exp_t      rd_q  [$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;

    dmem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_wr    (req_wr),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .memEn     (memEn),
        .memWrEn   (memWrEn),
        .memAddr   (memAddr),
        .dataIn    (dataIn),
        .dataOut   (dataOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: strobes captured mid-cycle, applied at the rising edge.
    initial begin
        logic        l_en;
        logic        l_wr;
        logic [7:0]  l_a;
        logic [63:0] l_d;
        for (int k = 0; k < 256; k++) begin
            mem[k] = 64'hF00D_0000_0000_0000 | 64'(k);
        end
        mem[8'h10] = 64'hDEADBEEF_00000001;
        dataOut = '0;
        forever begin
            @(negedge clk);
            l_en = memEn;
            l_wr = memWrEn;
            l_a  = memAddr;
            l_d  = dataIn;
            @(posedge clk);
            if (l_en === 1'b1) begin
                if (l_wr) mem[l_a] <= l_d;
                else      dataOut  <= mem[l_a];
            end
        end
    end

    // Monitor: pops expectations and compares mid-cycle.
    always @(negedge clk) begin
        port_exp_t e;
        port_exp_t a;
        rd_exp_t   r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {gnt, memEn, memWrEn, memAddr, dataIn};
            n_vec = n_vec + 1;
            if (a !== e) begin
                n_err = n_err + 1;
                $display("FAIL port cyc=%0d got gnt=%b en=%b wr=%b addr=%h din=%h want gnt=%b en=%b wr=%b addr=%h din=%h",
                         cyc, a.g, a.en, a.wr, a.a, a.d, e.g, e.en, e.wr, e.a, e.d);
            end
        end
        n_vec = n_vec + 1;
        if (rvalid !== 4'b0000) begin
            if (rd_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL rvalid_unexpected cyc=%0d got rvalid=%b rdata=%h want rvalid=0000", cyc, rvalid, rdata);
            end else begin
                r = rd_q.pop_front();
                if (rvalid !== r.tag || rdata !== r.data || cyc != r.due) begin
                    n_err = n_err + 1;
                    $display("FAIL rreturn cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h at cyc=%0d",
                             cyc, rvalid, rdata, r.tag, r.data, r.due);
                end
            end
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            n_err = n_err + 1;
            $display("FAIL rreturn_missing cyc=%0d got rvalid=%b want rvalid=%b rdata=%h", cyc, rvalid, r.tag, r.data);
        end else if (rdata !== 64'h0) begin
            n_err = n_err + 1;
            $display("FAIL rdata_idle cyc=%0d got rdata=%h want 0", cyc, rdata);
        end
    end

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0000;
        v[2'(3 - i)] = 1'b1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req       = '0;
        req_wr    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_slot(input int i, input logic wr, input logic lk, input logic [7:0] a, input logic [63:0] d);
        logic [1:0] b;
        b = 2'(3 - i);
        req[b]               = 1'b1;
        req_wr[b]            = wr;
        req_lock[b]          = lk;
        req_addr[8*b +: 8]   = a;
        req_wdata[64*b +: 64] = d;
    endtask

    task automatic exp_port(input logic [3:0] g, input logic wr, input logic [7:0] a, input logic [63:0] d);
        port_exp_t e;
        e = {g, (g != 4'b0000), wr, a, d};
        exp_q.push_back(e);
    endtask

    task automatic exp_idle();
        exp_port(4'b0000, 1'b0, 8'h00, 64'h0);
    endtask

    task automatic exp_rd(input int i, input logic [63:0] d);
        rd_exp_t r;
        r.tag  = oh(i);
        r.data = d;
        r.due  = cyc + 1;
        rd_q.push_back(r);
    endtask

    task automatic do_reset();
        next_cycle();
        clear_all();
        reset = 1'b1;
        exp_idle();
        next_cycle();
        reset = 1'b0;
        exp_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int         w;
        reset = 1'b1;
        clear_all();
        req = 4'b1111;

        // Grants stay low while reset is held, even with every request up.
        next_cycle();
        exp_idle();
        next_cycle();
        reset = 1'b0;
        clear_all();
        exp_idle();

        // Single read by requester 2.
        next_cycle();
        clear_all();
        set_slot(2, 1'b0, 1'b0, 8'h10, 64'h0);
        exp_port(4'b0010, 1'b0, 8'h10, 64'h0);
        exp_rd(2, 64'hDEADBEEF_00000001);
        next_cycle();
        clear_all();
        exp_idle();

        // Fairness: all four writing continuously from reset.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            clear_all();
            for (int i = 0; i < 4; i++) begin
                set_slot(i, 1'b1, 1'b0, 8'h40 + 8'(i), 64'h5555_0000_0000_0000 | 64'(i));
            end
            exp_port(oh(k % 4), 1'b1, 8'h40 + 8'(k % 4), 64'h5555_0000_0000_0000 | 64'(k % 4));
        end
        next_cycle();
        clear_all();
        exp_idle();

        // Write by requester 1, then read-back by requester 0.
        next_cycle();
        clear_all();
        set_slot(1, 1'b1, 1'b0, 8'h05, 64'h0123456789ABCDEF);
        exp_port(4'b0100, 1'b1, 8'h05, 64'h0123456789ABCDEF);
        next_cycle();
        clear_all();
        set_slot(0, 1'b0, 1'b0, 8'h05, 64'h0);
        exp_port(4'b1000, 1'b0, 8'h05, 64'h0);
        exp_rd(0, 64'h0123456789ABCDEF);
        next_cycle();
        clear_all();
        exp_idle();

        // Pipelined reads, requesters 0 and 3 each reading 0x00..0x03.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            clear_all();
            if ((k + 1) / 2 < 4) set_slot(0, 1'b0, 1'b0, 8'((k + 1) / 2), 64'h0);
            set_slot(3, 1'b0, 1'b0, 8'(k / 2), 64'h0);
            w = (k % 2 == 0) ? 0 : 3;
            a = 8'(k / 2);
            exp_port(oh(w), 1'b0, a, 64'h0);
            exp_rd(w, 64'hF00D_0000_0000_0000 | 64'(a));
        end
        next_cycle();
        clear_all();
        exp_idle();

        // Reset in the cycle after a read grant discards the return.
        next_cycle();
        clear_all();
        set_slot(2, 1'b0, 1'b0, 8'h10, 64'h0);
        exp_port(4'b0010, 1'b0, 8'h10, 64'h0);
        next_cycle();
        reset = 1'b1;
        clear_all();
        for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 1'b0, 8'h03, 64'h0);
        exp_idle();
        next_cycle();
        reset = 1'b0;
        exp_port(4'b1000, 1'b0, 8'h03, 64'h0);
        exp_rd(0, 64'hF00D_0000_0000_0003);
        next_cycle();
        clear_all();
        exp_idle();

        // Lock sequence: requester 1 read-modify-write on 0x20 against requester 0.
        next_cycle();
        clear_all();
        set_slot(0, 1'b0, 1'b0, 8'h01, 64'h0);
        set_slot(1, 1'b0, 1'b1, 8'h20, 64'h0);
        exp_port(4'b0100, 1'b0, 8'h20, 64'h0);
        exp_rd(1, 64'hF00D_0000_0000_0020);
`ifdef DMEM_ARB_LOCK_EN
        next_cycle();
        clear_all();
        set_slot(0, 1'b0, 1'b0, 8'h01, 64'h0);
        set_slot(1, 1'b1, 1'b0, 8'h20, 64'hCAFE_F00D_0000_0021);
        exp_port(4'b0100, 1'b1, 8'h20, 64'hCAFE_F00D_0000_0021);
        next_cycle();
        clear_all();
        set_slot(0, 1'b0, 1'b0, 8'h01, 64'h0);
        exp_port(4'b1000, 1'b0, 8'h01, 64'h0);
        exp_rd(0, 64'hF00D_0000_0000_0001);
`else
        next_cycle();
        clear_all();
        set_slot(0, 1'b0, 1'b0, 8'h01, 64'h0);
        set_slot(1, 1'b1, 1'b0, 8'h20, 64'hCAFE_F00D_0000_0021);
        exp_port(4'b1000, 1'b0, 8'h01, 64'h0);
        exp_rd(0, 64'hF00D_0000_0000_0001);
        next_cycle();
        clear_all();
        set_slot(1, 1'b1, 1'b0, 8'h20, 64'hCAFE_F00D_0000_0021);
        exp_port(4'b0100, 1'b1, 8'h20, 64'hCAFE_F00D_0000_0021);
`endif
        next_cycle();
        clear_all();
        exp_idle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
